rx_bit_timer: RTL and testbench
===============================

Name: rx_bit_timer

Overview:
Parametrised bit-timing and word-framing generator for the USB receive path. It tracks bit phase from data edges on the decoded line and issues one sample strobe per bit period at a programmable phase. It removes stuffed bits from the shift stream, counts data bits into words, and flags an idle/stuck-line timeout. It sits between the edge detector / NRZI decoder and the receive shift register / RX controller FSM.

Parameters:
CLKS_PER_BIT, 8, system clocks per bit period; must be >= 3.
SAMPLE_PHASE, 4, clocks after a resync edge at which the bit is sampled; legal range 1..CLKS_PER_BIT-1.
WORD_BITS, 8, data bits per received word; must be >= 2.
IDLE_BITS, 7, consecutive sampled bits with no edge before idle_timeout sets; must be >= 1.

Ports:
clk  input  1  system clock; all state updates on its rising edge
rst  input  1  synchronous reset, active-high
rx_transfer_active  input  1  high while a packet is being received; low clears all timing state
d_edge  input  1  one-cycle pulse on each transition of the received line
stuff_bit  input  1  from decoder; qualifies the current sample_strobe as a stuffed bit
sample_strobe  output  1  one-cycle pulse at the sample point of every bit, stuffed or not
shift_enable  output  1  sample_strobe & ~stuff_bit; shifts a data bit into the RX shift register
byte_received  output  1  one-cycle pulse when WORD_BITS data bits have been shifted
bit_index  output  $clog2(WORD_BITS)  number of data bits already shifted in the current word
idle_timeout  output  1  sticky; set after IDLE_BITS edge-free bit periods

Behaviour:
- One clock domain: clk. Reset is synchronous and active-high on rst. When rst is high at a clock edge, all registers clear: phase counter ph=0, bit_cnt=0, idle_cnt=0, sample_strobe=0, byte_received=0, idle_timeout=0. Reset mid-transfer aborts the word in progress with no byte_received pulse.
- Inactive state: while rx_transfer_active=0, ph, bit_cnt and idle_cnt are held at 0, idle_timeout is cleared, and no strobes are issued. d_edge and stuff_bit are ignored.
- Phase counter (width $clog2(CLKS_PER_BIT)), updated while active:
  - if d_edge=1, next ph=1;
  - otherwise next ph = (ph==CLKS_PER_BIT-1) ? 0 : ph+1.
  - The first active cycle counts as phase 0 because ph is held at 0 while inactive.
- sample_strobe is a registered pulse, high in exactly the cycles where rx_transfer_active=1 and ph==SAMPLE_PHASE.
  - Edge or activation at cycle T gives sample_strobe at T+SAMPLE_PHASE.
  - With no further edges, strobes repeat every CLKS_PER_BIT cycles.
  - If d_edge coincides with ph==SAMPLE_PHASE, the strobe still fires that cycle and ph reloads to 1.
  - If an edge arrives before the sample point, the pending sample is pushed out, so there are never two strobes closer than SAMPLE_PHASE cycles.
- shift_enable = sample_strobe & ~stuff_bit. This is combinational in the same cycle; it is the only input-to-output combinational path.
- Word framing:
  - On each shift_enable, bit_cnt increments.
  - On the shift_enable that completes bit WORD_BITS, bit_cnt wraps to 0 and byte_received pulses for one cycle on the next clock edge. At that point the shift register already holds the last bit.
  - Stuffed bits do not advance bit_cnt.
  - bit_index = bit_cnt.
- Idle timeout:
  - idle_cnt (width $clog2(IDLE_BITS+1)) increments on each sample_strobe and saturates at IDLE_BITS.
  - Any d_edge clears idle_cnt to 0; a clear and a strobe in the same cycle give idle_cnt=0.
  - idle_timeout is registered. It sets the cycle after idle_cnt reaches IDLE_BITS and stays high until d_edge, rx_transfer_active=0 or rst.
  - Strobes and framing continue while idle_timeout is high; the RX controller decides whether to abort.
- rx_transfer_active falling mid-word: bit_cnt is discarded with no pulse. The next activation starts a fresh word at bit_index=0.

Test Plan:
- Defaults, activate at cycle 0, no edges: sample_strobe at cycles 4,12,20,...; byte_received once, at cycle 61 (after the 8th strobe at cycle 60); bit_index counts 0..7 then back to 0.
- Resync: activate at 0; d_edge at cycle 10 (mid-bit) -> second strobe moves from cycle 12 to cycle 14, third at 22; d_edge coincident with ph==4 -> strobe fires and the next strobe is 4 cycles later.
- Bit stuffing: stuff_bit=1 on the 3rd strobe -> shift_enable suppressed on that strobe, sample_strobe still pulses, byte_received only after 9 strobes total.
- Idle: active with no edges -> idle_timeout rises one cycle after the 7th strobe and stays high; a single d_edge clears it the next cycle and idle_cnt restarts from 0.
- Abort/reset: deassert rx_transfer_active at bit_index=5 -> no byte_received, outputs go low; re-activate -> first strobe 4 cycles later at bit_index 0. Repeat using rst=1 for one cycle mid-word -> same result.
- Parameter sweep with CLKS_PER_BIT=12, SAMPLE_PHASE=6, WORD_BITS=16, IDLE_BITS=3 -> strobe period 12 with first strobe at cycle 6; byte_received after 16 data bits; idle_timeout after 3 edge-free bits.

Source files
------------

// File: rtl/rx_bit_timer_if.sv
// rx_bit_timer_if: bit-timing and word-framing signals between the NRZI decoder, the bit timer and the RX controller.
interface rx_bit_timer_if #(
  parameter int WORD_BITS = 8
);
  logic rx_transfer_active;
  logic d_edge;
  logic stuff_bit;
  logic sample_strobe;
  logic shift_enable;
  logic byte_received;
  logic [$clog2(WORD_BITS)-1:0] bit_index;
  logic idle_timeout;
  modport master (
    output rx_transfer_active, d_edge, stuff_bit,
    input  sample_strobe, shift_enable, byte_received, bit_index, idle_timeout
  );
  modport slave (
    input  rx_transfer_active, d_edge, stuff_bit,
    output sample_strobe, shift_enable, byte_received, bit_index, idle_timeout
  );
endinterface

// File: rtl/rx_bit_timer.sv
// rx_bit_timer: edge-resynchronised bit sampler with stuffed-bit removal, word framing and idle-line timeout.
module rx_bit_timer #(
  parameter int CLKS_PER_BIT = 8,
  parameter int SAMPLE_PHASE = 4,
  parameter int WORD_BITS    = 8,
  parameter int IDLE_BITS    = 7
) (
  input  logic           clk,
  input  logic           rst,
  rx_bit_timer_if.slave  bus
);
  localparam int PW = $clog2(CLKS_PER_BIT);
  localparam int BW = $clog2(WORD_BITS);
  localparam int IW = $clog2(IDLE_BITS + 1);
  logic [PW-1:0] ph_q, ph_d;
  logic [BW-1:0] bit_cnt_q, bit_cnt_d;
  logic [IW-1:0] idle_cnt_q, idle_cnt_d;
  logic strobe_q, byte_q, idle_q, act, d_edge, shift;
  assign act    = bus.rx_transfer_active;
  assign d_edge = bus.d_edge;
  assign shift  = strobe_q & ~bus.stuff_bit;
  always_comb begin
    ph_d       = !act ? '0 : d_edge ? PW'(1) : (ph_q == PW'(CLKS_PER_BIT - 1)) ? '0 : ph_q + 1'b1;
    bit_cnt_d  = !act ? '0 : !shift ? bit_cnt_q : (bit_cnt_q == BW'(WORD_BITS - 1)) ? '0 : bit_cnt_q + 1'b1;
    idle_cnt_d = (!act || d_edge) ? '0 : (strobe_q && idle_cnt_q != IW'(IDLE_BITS)) ? idle_cnt_q + 1'b1 : idle_cnt_q;
  end
  // strobe is registered from next phase so it lines up with ph_q==SAMPLE_PHASE
  always_ff @(posedge clk) begin
    if (rst) begin
      ph_q       <= '0;
      bit_cnt_q  <= '0;
      idle_cnt_q <= '0;
      strobe_q   <= 1'b0;
      byte_q     <= 1'b0;
      idle_q     <= 1'b0;
    end else begin
      ph_q       <= ph_d;
      bit_cnt_q  <= bit_cnt_d;
      idle_cnt_q <= idle_cnt_d;
      strobe_q   <= act && (ph_d == PW'(SAMPLE_PHASE));
      byte_q     <= act && shift && (bit_cnt_q == BW'(WORD_BITS - 1));
      idle_q     <= act && !d_edge && (idle_q || idle_cnt_d == IW'(IDLE_BITS));
    end
  end
  assign bus.sample_strobe = strobe_q;
  assign bus.shift_enable  = shift;
  assign bus.byte_received = byte_q;
  assign bus.bit_index     = bit_cnt_q;
  assign bus.idle_timeout  = idle_q;
endmodule

// File: tb/tb_rx_bit_timer.sv
// tb_rx_bit_timer: directed vector tables and hand sequences for the receive bit timer at default and swept parameters.
module tb_rx_bit_timer;
  logic clk = 1'b0;
  logic rst_a, rst_b;
  always #5 clk = ~clk;
  rx_bit_timer_if #(.WORD_BITS(8))  a();
  rx_bit_timer_if #(.WORD_BITS(16)) b();
  rx_bit_timer dut_a (.clk(clk), .rst(rst_a), .bus(a.slave));
  rx_bit_timer #(.CLKS_PER_BIT(12), .SAMPLE_PHASE(6), .WORD_BITS(16), .IDLE_BITS(3))
    dut_b (.clk(clk), .rst(rst_b), .bus(b.slave));
  typedef struct {int cyc; bit e; bit s; bit st; bit sh; bit by; int ix; bit id;} vec_t;
  vec_t tab[$];
  int total = 0, passed = 0;
  task automatic chk(string nm, int got, int exp);
    total++;
    if (got == exp) passed++;
    else $display("FAIL %s at %0t: got %0d expected %0d", nm, $time, got, exp);
  endtask
  function automatic void v(int c, bit e, bit s, bit st, bit sh, bit by, int ix, bit id);
    tab.push_back('{c, e, s, st, sh, by, ix, id});
  endfunction
  task automatic restart_a();
    a.rx_transfer_active = 1'b0;
    @(posedge clk); #1;
    a.rx_transfer_active = 1'b1;
  endtask
  task automatic run_tab(int last);
    for (int c = 0; c <= last; c++) begin
      a.d_edge = 1'b0;
      a.stuff_bit = 1'b0;
      foreach (tab[i]) if (tab[i].cyc == c) begin
        a.d_edge = tab[i].e;
        a.stuff_bit = tab[i].s;
      end
      @(negedge clk);
      foreach (tab[i]) if (tab[i].cyc == c) begin
        chk($sformatf("strobe c%0d", c), int'(a.sample_strobe), int'(tab[i].st));
        chk($sformatf("shift c%0d", c), int'(a.shift_enable), int'(tab[i].sh));
        chk($sformatf("byte c%0d", c), int'(a.byte_received), int'(tab[i].by));
        chk($sformatf("idx c%0d", c), int'(a.bit_index), tab[i].ix);
        chk($sformatf("idle c%0d", c), int'(a.idle_timeout), int'(tab[i].id));
      end
      @(posedge clk); #1;
    end
    a.d_edge = 1'b0;
    a.stuff_bit = 1'b0;
    tab.delete();
  endtask
  task automatic abort_seq(bit use_rst);
    int bytes = 0;
    restart_a();
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (a.byte_received) bytes++;
      @(posedge clk); #1;
    end
    chk("pre-abort idx", int'(a.bit_index), 5);
    if (use_rst) rst_a = 1'b1;
    else a.rx_transfer_active = 1'b0;
    @(posedge clk); #1;
    rst_a = 1'b0;
    if (!use_rst) begin
      for (int k = 0; k < 5; k++) begin
        @(negedge clk);
        chk("inactive strobe", int'(a.sample_strobe), 0);
        chk("inactive idx", int'(a.bit_index), 0);
        @(posedge clk); #1;
      end
      a.rx_transfer_active = 1'b1;
    end
    for (int k = 0; k <= 5; k++) begin
      @(negedge clk);
      if (a.byte_received) bytes++;
      chk($sformatf("restart strobe k%0d", k), int'(a.sample_strobe), int'(k == 4));
      if (k == 0) chk("restart idx", int'(a.bit_index), 0);
      if (k == 4) chk("restart shift", int'(a.shift_enable), 1);
      if (k == 4) chk("restart idx at strobe", int'(a.bit_index), 0);
      if (k == 5) chk("restart idx after", int'(a.bit_index), 1);
      @(posedge clk); #1;
    end
    chk(use_rst ? "no byte on rst abort" : "no byte on inactive abort", bytes, 0);
  endtask
  initial begin
    a.rx_transfer_active = 1'b1; a.d_edge = 1'b0; a.stuff_bit = 1'b0;
    b.rx_transfer_active = 1'b0; b.d_edge = 1'b0; b.stuff_bit = 1'b0;
    rst_a = 1'b1; rst_b = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset strobe", int'(a.sample_strobe), 0);
    chk("reset byte", int'(a.byte_received), 0);
    chk("reset idx", int'(a.bit_index), 0);
    chk("reset idle", int'(a.idle_timeout), 0);
    chk("reset b strobe", int'(b.sample_strobe), 0);
    @(posedge clk); #1;
    rst_a = 1'b0; rst_b = 1'b0;
    // free-running word, idle timeout, edge clearing, coincident edge
    restart_a();
    v(0, 0,0, 0,0,0, 0,0); v(4, 0,0, 1,1,0, 0,0); v(5, 0,0, 0,0,0, 1,0);
    v(12,0,0, 1,1,0, 1,0); v(52,0,0, 1,1,0, 6,0); v(53,0,0, 0,0,0, 7,1);
    v(60,0,0, 1,1,0, 7,1); v(61,0,0, 0,0,1, 0,1); v(62,0,0, 0,0,0, 0,1);
    v(70,1,0, 0,0,0, 1,1); v(71,0,0, 0,0,0, 1,0); v(73,0,0, 0,0,0, 1,0);
    v(74,0,0, 1,1,0, 1,0); v(75,0,0, 0,0,0, 2,0); v(122,0,0,1,1,0, 7,0);
    v(123,0,0,0,0,1, 0,1); v(130,1,0,1,1,0, 0,1); v(131,0,0,0,0,0, 1,0);
    v(133,0,0,0,0,0, 1,0); v(134,0,0,1,1,0, 1,0); v(135,0,0,0,0,0, 2,0);
    v(138,0,0,0,0,0, 2,0);
    run_tab(140);
    // mid-bit resync and a stuffed third bit
    restart_a();
    v(0, 0,0, 0,0,0, 0,0); v(4, 0,0, 1,1,0, 0,0); v(10,1,0, 0,0,0, 1,0);
    v(12,0,0, 0,0,0, 1,0); v(14,0,0, 1,1,0, 1,0); v(15,0,0, 0,0,0, 2,0);
    v(22,0,1, 1,0,0, 2,0); v(23,0,0, 0,0,0, 2,0); v(30,0,0, 1,1,0, 2,0);
    v(62,0,0, 1,1,0, 6,0); v(63,0,0, 0,0,0, 7,1); v(70,0,0, 1,1,0, 7,1);
    v(71,0,0, 0,0,1, 0,1);
    run_tab(72);
    abort_seq(1'b0);
    abort_seq(1'b1);
    @(posedge clk); #1;
    b.rx_transfer_active = 1'b1;
    for (int c = 0; c < 196; c++) begin
      @(negedge clk);
      chk($sformatf("p strobe c%0d", c), int'(b.sample_strobe), int'(c >= 6 && (c - 6) % 12 == 0));
      chk($sformatf("p byte c%0d", c), int'(b.byte_received), int'(c == 187));
      chk($sformatf("p idle c%0d", c), int'(b.idle_timeout), int'(c >= 31));
      chk($sformatf("p idx c%0d", c), int'(b.bit_index), (c <= 6) ? 0 : ((c - 7) / 12 + 1) % 16);
      @(posedge clk); #1;
    end
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
